chroni_vram_arbiter: RTL
========================

// Module: chroni_vram_arbiter
// PURPOSE
//  Two-port arbiter in front of the single-port synchronous VRAM. Serves chroni's video fetch port
//  (rd_req/rd_ack, {addr_out_page,addr_out}) and the CPU VRAM window (req/ack, read or write).
//  Video has priority. A starvation counter guarantees the CPU a slot. Returns read data with a one-cycle ack.
// PARAMETERS
//  RAM_AW      17   physical VRAM address width in bits; the low RAM_AW bits of the 21-bit VRAM address are used
//  CPU_MAXWAIT 15   number of cycles a pending CPU request may be blocked before it is forced through
// PORTS
//  vga_clk     in   1        clock, all logic on rising edge
//  reset_n     in   1        synchronous, active-low reset
//  vid_req     in   1        chroni rd_req; level, held high across back-to-back reads
//  vid_addr    in   21       {addr_out_page, addr_out}
//  vid_ack     out  1        one-cycle pulse; vid_data valid in the same cycle
//  vid_data    out  8        read data to chroni data_in
//  cpu_req     in   1        CPU access request; level, held until cpu_ack
//  cpu_we      in   1        1 = write, 0 = read; stable while cpu_req is high
//  cpu_addr    in   21       CPU VRAM address
//  cpu_wdata   in   8        write data
//  cpu_ack     out  1        one-cycle pulse; access completed, cpu_rdata valid for reads
//  cpu_rdata   out  8        read data, held until the next CPU read completes
//  ram_addr    out  RAM_AW   to VRAM
//  ram_we      out  1        VRAM write strobe
//  ram_wdata   out  8        VRAM write data
//  ram_rdata   in   8        VRAM data, registered: valid the cycle after ram_addr is presented
// BEHAVIOUR
//  Reset values: state=IDLE; vid_ack=0, cpu_ack=0, ram_we=0, ram_addr=0, ram_wdata=0; vid_data=0, cpu_rdata=0; wait_cnt=0.
//  Reset mid-transaction aborts the access. No ack is issued for it and no write is issued.
//  FSM (one state per cycle):
//   IDLE   : if force_cpu && cpu_req -> C_ADDR
//            else if vid_req -> V_ADDR
//            else if cpu_req -> C_ADDR
//            else stay in IDLE.
//   V_ADDR : ram_addr <= vid_addr[RAM_AW-1:0]; ram_we=0; -> V_DATA.
//   V_DATA : vid_data <= ram_rdata; vid_ack=1 for exactly this cycle; -> V_TURN.
//   V_TURN : dead cycle. chroni updates its address on the edge that sees the ack, so vid_addr is not
//            sampled here. -> IDLE.
//   C_ADDR : ram_addr <= cpu_addr[RAM_AW-1:0].
//            if cpu_we: ram_we=1, ram_wdata=cpu_wdata for this one cycle, then -> C_DONE.
//            else: -> C_DATA.
//   C_DATA : cpu_rdata <= ram_rdata; -> C_DONE.
//   C_DONE : cpu_ack=1 for exactly this cycle; -> IDLE.
//            The CPU must drop or renew cpu_req by the next edge. cpu_req still high in IDLE is a new request.
//  Latency:
//   video read: vid_req seen in IDLE -> ack 2 cycles later. Back-to-back reads cost 4 cycles each.
//   CPU access, uncontended: write acked at cycle 2, read acked at cycle 3 after IDLE sees cpu_req.
//  Starvation counter wait_cnt, 4 bits:
//   increments each cycle that cpu_req=1 and the FSM is not in a C_* state; saturates at CPU_MAXWAIT.
//   clears on cpu_ack.
//   force_cpu = (wait_cnt == CPU_MAXWAIT).
//  Simultaneous vid_req and cpu_req in IDLE: video wins unless force_cpu.
//  vid_req dropping while in V_*: the access completes and the ack is still pulsed (chroni ignores it when idle).
//  Address wrap: bits above RAM_AW are ignored, so VRAM aliases modulo 2^RAM_AW.
//  vid_ack and cpu_ack are never high in the same cycle. ram_we is high only in C_ADDR with cpu_we=1.
// STRUCTURE
//  Shared package chroni_pkg.vh gets:
//   state encodings ARB_IDLE..ARB_C_DONE (3 bits);
//   VRAM_AW_FULL = 21;
//   default RAM_AW.
//  Single flat module. No sub-module is natural: FSM, wait counter and data registers only.
// TESTING
//  1. Reset: hold reset_n=0 with vid_req=cpu_req=1 for 3 cycles
//     -> all acks 0, ram_we 0, state IDLE; first ack appears only after reset release.
//  2. Video stream: preload RAM[0x0401]=0x41, RAM[0x2088]=0x3C. vid_req=1, vid_addr=0x0401, change to 0x2088
//     on ack -> vid_data 0x41 then 0x3C; acks exactly 4 cycles apart.
//  3. CPU write/read: cpu write 0x1234<-0xA5, then read 0x1234 with vid_req=0
//     -> ram_we single cycle, write ack at cycle 2; read ack at cycle 3 with cpu_rdata=0xA5.
//  4. Starvation: vid_req held 1, cpu_req read of 0x0010 (=0x5A)
//     -> cpu_ack within CPU_MAXWAIT+8 cycles with 0x5A; the video stream resumes after the CPU slot.
//  5. Collision: vid_req and cpu_req rise in the same cycle, wait_cnt=0
//     -> video served first; vid_ack and cpu_ack never coincide.
//  6. Alias/abort: cpu_addr=0x1_FFFF+1 (bit 17 set) writes RAM[0]; reset asserted in C_ADDR of a write
//     -> no ack, no ram_we after reset.

Source files
------------

// File: rtl/chroni_vram_arbiter_pkg.sv
// Shared constants and state encoding for the chroni VRAM arbiter.
package chroni_vram_arbiter_pkg;
    localparam int VRAM_AW_FULL    = 21;
    localparam int RAM_AW_DEF      = 17;
    localparam int CPU_MAXWAIT_DEF = 15;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_V_ADDR = 3'd1,
        ARB_V_DATA = 3'd2,
        ARB_V_TURN = 3'd3,
        ARB_C_ADDR = 3'd4,
        ARB_C_DATA = 3'd5,
        ARB_C_DONE = 3'd6
    } arb_state_e;

    function automatic logic is_cpu_state(arb_state_e s);
        return (s == ARB_C_ADDR) || (s == ARB_C_DATA) || (s == ARB_C_DONE);
    endfunction
endpackage

// File: rtl/chroni_vram_arbiter_if.sv
// Requester-side bus of the VRAM arbiter: chroni video fetch port and CPU VRAM window.
interface chroni_vram_arbiter_if;
    import chroni_vram_arbiter_pkg::*;

    logic                    vid_req;
    logic [VRAM_AW_FULL-1:0] vid_addr;
    logic                    vid_ack;
    logic [7:0]              vid_data;

    logic                    cpu_req;
    logic                    cpu_we;
    logic [VRAM_AW_FULL-1:0] cpu_addr;
    logic [7:0]              cpu_wdata;
    logic                    cpu_ack;
    logic [7:0]              cpu_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_ack, vid_data, cpu_ack, cpu_rdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_ack, vid_data, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Arbitrates chroni video reads and CPU accesses onto the single-port synchronous VRAM.
// Video has priority; a saturating wait counter forces a pending CPU request through.
module chroni_vram_arbiter
    import chroni_vram_arbiter_pkg::*;
#(
    parameter int RAM_AW      = RAM_AW_DEF,
    parameter int CPU_MAXWAIT = CPU_MAXWAIT_DEF
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    chroni_vram_arbiter_if.slave bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    arb_state_e state;
    logic [3:0] wait_cnt;
    logic [7:0] vid_data_q;
    logic       force_cpu;

    assign force_cpu = (wait_cnt == 4'(CPU_MAXWAIT));

    // RAM data only lands in V_DATA, the ack cycle, so it is forwarded then and held afterwards.
    assign bus.vid_data = (state == ARB_V_DATA) ? ram_rdata : vid_data_q;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state         <= ARB_IDLE;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= 8'h00;
            bus.vid_ack   <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= 8'h00;
            vid_data_q    <= 8'h00;
        end else begin
            bus.vid_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            ram_we      <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (bus.cpu_req && (force_cpu || !bus.vid_req)) begin
                        state     <= ARB_C_ADDR;
                        ram_addr  <= bus.cpu_addr[RAM_AW-1:0];
                        ram_we    <= bus.cpu_we;
                        ram_wdata <= bus.cpu_wdata;
                    end else if (bus.vid_req) begin
                        state    <= ARB_V_ADDR;
                        ram_addr <= bus.vid_addr[RAM_AW-1:0];
                    end
                end
                ARB_V_ADDR: begin
                    state       <= ARB_V_DATA;
                    bus.vid_ack <= 1'b1;
                end
                ARB_V_DATA: begin
                    vid_data_q <= ram_rdata;
                    state      <= ARB_V_TURN;
                end
                // chroni moves its address on the ack edge; give it a cycle before IDLE samples it.
                ARB_V_TURN: state <= ARB_IDLE;
                ARB_C_ADDR: begin
                    if (ram_we) begin
                        state       <= ARB_C_DONE;
                        bus.cpu_ack <= 1'b1;
                    end else begin
                        state <= ARB_C_DATA;
                    end
                end
                ARB_C_DATA: begin
                    bus.cpu_rdata <= ram_rdata;
                    bus.cpu_ack   <= 1'b1;
                    state         <= ARB_C_DONE;
                end
                ARB_C_DONE: state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n)
            wait_cnt <= 4'd0;
        else if (bus.cpu_ack)
            wait_cnt <= 4'd0;
        else if (bus.cpu_req && !is_cpu_state(state) && !force_cpu)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Address bits above RAM_AW alias by design.
    if (RAM_AW < VRAM_AW_FULL) begin : g_alias
        logic unused_hi;
        assign unused_hi = ^{bus.vid_addr[VRAM_AW_FULL-1:RAM_AW], bus.cpu_addr[VRAM_AW_FULL-1:RAM_AW]};
    end
endmodule
